// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory operation sequencer: command modes,
// FSM state encoding and default bus widths.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] MODE_CLEAR = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_NOP   = 2'b11;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK   = 3'd2;
  localparam logic [2:0] ST_WAIT_RDATA = 3'd3;
  localparam logic [2:0] ST_CLR_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_ISSUE      = ST_ISSUE,
    S_WAIT_ACK   = ST_WAIT_ACK,
    S_WAIT_RDATA = ST_WAIT_RDATA,
    S_CLR_NEXT   = ST_CLR_NEXT,
    S_DONE       = ST_DONE
  } state_e;

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Command strobe from the I/O controller plus the req/ack memory port.
// master = sequencer side, slave = I/O controller and memory side.
interface mem_op_sequencer_if #(
  parameter int ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DEF_DATA_W
);

  logic              ioDone;
  logic [1:0]        modeIn;
  logic [ADDR_W-1:0] addrIn;
  logic [DATA_W-1:0] dataIn;

  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memAck;
  logic              memRvalid;
  logic [DATA_W-1:0] memRdata;

  logic              memDone;
  logic [DATA_W-1:0] rdData;
  logic              errFlag;

  modport master (
    input  ioDone, modeIn, addrIn, dataIn,
    input  memAck, memRvalid, memRdata,
    output memReq, memWe, memAddr, memWdata,
    output memDone, rdData, errFlag
  );

  modport slave (
    output ioDone, modeIn, addrIn, dataIn,
    output memAck, memRvalid, memRdata,
    input  memReq, memWe, memAddr, memWdata,
    input  memDone, rdData, errFlag
  );

endinterface

// File: rtl/mem_timeout_timer.sv
// Wait-cycle counter: o_expire is high on the TIMEOUT_CYCLES-th enabled cycle
// after i_clear; the count saturates there until cleared.
module mem_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count holds elapsed wait cycles minus one, so the limit cycle itself expires.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LP_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_enable && (r_cnt == LP_LAST);

endmodule

// File: rtl/mem_op_sequencer.sv
// Runs one write, read or clear sweep per ioDone rising edge over a req/ack port.
// Busy (memDone=0) from ISSUE through DONE; edges while busy are dropped.
module mem_op_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CLEAR_WORDS    = 1024,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_op_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LP_CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_io_prev;
  logic              w_io_rise;
  logic              w_accept;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_rdData;
  logic              r_errFlag;
  logic              w_tmr_clear;
  logic              w_tmr_en;
  logic              w_tmr_expire;

  assign w_io_rise = bus.ioDone & ~r_io_prev;
  assign w_accept  = w_io_rise && (bus.modeIn != MODE_NOP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // The awaited event beats a timeout landing on the same cycle.
        if (bus.memAck) begin
          if (r_mode == MODE_READ) begin
            w_state_nxt = bus.memRvalid ? S_DONE : S_WAIT_RDATA;
          end else if (r_mode == MODE_CLEAR) begin
            w_state_nxt = S_CLR_NEXT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (w_tmr_expire) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_RDATA: begin
        if (bus.memRvalid || w_tmr_expire) w_state_nxt = S_DONE;
      end
      S_CLR_NEXT: begin
        w_state_nxt = (r_clr_cnt == LP_CLR_LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Any state change restarts the timer, so each wait state starts from zero.
  assign w_tmr_en    = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_RDATA);
  assign w_tmr_clear = (w_state_nxt != r_state);

  mem_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_expire (w_tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_io_prev  <= 1'b0;
      r_mode     <= MODE_CLEAR;
      r_clr_cnt  <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_rdData   <= '0;
      r_errFlag  <= 1'b0;
    end else begin
      r_io_prev <= bus.ioDone;
      r_state   <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          // Request fields are set up on entry to ISSUE; memReq follows a cycle later.
          if (w_accept) begin
            r_mode     <= bus.modeIn;
            r_errFlag  <= 1'b0;
            r_clr_cnt  <= '0;
            r_memWe    <= (bus.modeIn != MODE_READ);
            r_memAddr  <= (bus.modeIn == MODE_CLEAR) ? '0 : bus.addrIn;
            r_memWdata <= (bus.modeIn == MODE_WRITE) ? bus.dataIn : '0;
          end
        end
        S_ISSUE: begin
          r_memReq <= 1'b1;
        end
        S_WAIT_ACK: begin
          if (bus.memAck) begin
            r_memReq <= 1'b0;
            if ((r_mode == MODE_READ) && bus.memRvalid) r_rdData <= bus.memRdata;
          end else if (w_tmr_expire) begin
            r_memReq  <= 1'b0;
            r_errFlag <= 1'b1;
          end
        end
        S_WAIT_RDATA: begin
          if (bus.memRvalid) begin
            r_rdData <= bus.memRdata;
          end else if (w_tmr_expire) begin
            r_errFlag <= 1'b1;
          end
        end
        S_CLR_NEXT: begin
          if (r_clr_cnt != LP_CLR_LAST) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            r_memAddr <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.memReq   = r_memReq;
  assign bus.memWe    = r_memWe;
  assign bus.memAddr  = r_memAddr;
  assign bus.memWdata = r_memWdata;
  assign bus.memDone  = (r_state == S_IDLE);
  assign bus.rdData   = r_rdData;
  assign bus.errFlag  = r_errFlag;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Scoreboard bench: expected memory requests are queued when a command is driven
// and compared on every request cycle, popped on ack.
module tb_mem_op_sequencer;

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [15:0] wdata;
    logic        chk_wd;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  req_t exp_q[$];

  int req_hi_cnt    = 0;
  int req_rise_cnt  = 0;
  int busy_cnt      = 0;
  int done_rise_cnt = 0;

  int          ack_delay = 0;
  int          rv_delay  = 0;
  logic [15:0] rd_val    = 16'h0000;

  mem_op_sequencer_if #(.ADDR_W(25), .DATA_W(16)) bus ();

  mem_op_sequencer #(
    .ADDR_W         (25),
    .DATA_W         (16),
    .CLEAR_WORDS    (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [24:0] addr, input logic [15:0] wdata,
                          input logic chk_wd);
    req_t r;
    r.we     = we;
    r.addr   = addr;
    r.wdata  = wdata;
    r.chk_wd = chk_wd;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic [1:0] m, input logic [24:0] a, input logic [15:0] d);
    @(posedge clk); #2;
    bus.modeIn = m;
    bus.addrIn = a;
    bus.dataIn = d;
    bus.ioDone = 1'b1;
    @(posedge clk); #2;
    bus.ioDone = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int b0);
    int n;
    n = 0;
    while (!(bus.memDone === 1'b1 && busy_cnt > b0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_done"}, 32'(bus.memDone), 32'd1);
  endtask

  // Memory model: acks the ack_delay-th request cycle; read data after rv_delay cycles.
  initial begin
    int req_idx;
    int rv_cd;
    req_idx = 0;
    rv_cd   = 0;
    bus.memAck    = 1'b0;
    bus.memRvalid = 1'b0;
    bus.memRdata  = 16'h0000;
    forever begin
      @(posedge clk); #2;
      bus.memAck    = 1'b0;
      bus.memRvalid = 1'b0;
      if (rst) begin
        req_idx = 0;
        rv_cd   = 0;
      end else begin
        if (rv_cd > 0) begin
          rv_cd--;
          if (rv_cd == 0) begin
            bus.memRvalid = 1'b1;
            bus.memRdata  = rd_val;
          end
        end
        if (bus.memReq) begin
          if (req_idx == ack_delay) begin
            bus.memAck = 1'b1;
            if (!bus.memWe) begin
              if (rv_delay == 0) begin
                bus.memRvalid = 1'b1;
                bus.memRdata  = rd_val;
              end else begin
                rv_cd = rv_delay;
              end
            end
          end
          req_idx++;
        end else begin
          req_idx = 0;
        end
      end
    end
  end

  // Monitor: request fields are compared on every request cycle, not just at ack.
  initial begin
    logic prev_req;
    logic prev_done;
    prev_req  = 1'b0;
    prev_done = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req  = 1'b0;
        prev_done = 1'b1;
      end else begin
        if (bus.memReq) begin
          req_hi_cnt++;
          if (!prev_req) req_rise_cnt++;
          if (exp_q.size() == 0) begin
            check_eq("req_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            check_eq("req_we", 32'(bus.memWe), 32'(exp_q[0].we));
            check_eq("req_addr", 32'(bus.memAddr), 32'(exp_q[0].addr));
            if (exp_q[0].chk_wd) check_eq("req_wdata", 32'(bus.memWdata), 32'(exp_q[0].wdata));
            if (bus.memAck) void'(exp_q.pop_front());
          end
        end
        if (!bus.memDone) busy_cnt++;
        else if (!prev_done) done_rise_cnt++;
        prev_req  = bus.memReq;
        prev_done = bus.memDone;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int r0;
    int d0;
    int h0;
    logic found;

    bus.ioDone = 1'b0;
    bus.modeIn = 2'b11;
    bus.addrIn = '0;
    bus.dataIn = '0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_memReq", 32'(bus.memReq), 32'd0);
    check_eq("rst_memWe", 32'(bus.memWe), 32'd0);
    check_eq("rst_memAddr", 32'(bus.memAddr), 32'd0);
    check_eq("rst_memWdata", 32'(bus.memWdata), 32'd0);
    check_eq("rst_rdData", 32'(bus.rdData), 32'd0);
    check_eq("rst_errFlag", 32'(bus.errFlag), 32'd0);
    check_eq("rst_memDone", 32'(bus.memDone), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single write, ack on the second request cycle
    ack_delay = 1;
    push_req(1'b1, 25'h0001234, 16'hBEEF, 1'b1);
    b0 = busy_cnt; r0 = req_rise_cnt; d0 = done_rise_cnt;
    issue(2'b10, 25'h0001234, 16'hBEEF);
    wait_done("wr", b0);
    check_eq("wr_busy", 32'(busy_cnt - b0), 32'd4);
    check_eq("wr_reqs", 32'(req_rise_cnt - r0), 32'd1);
    check_eq("wr_done_rise", 32'(done_rise_cnt - d0), 32'd1);
    check_eq("wr_err", 32'(bus.errFlag), 32'd0);
    check_eq("wr_q", 32'(exp_q.size()), 32'd0);

    // Read, data three cycles after ack
    ack_delay = 0; rv_delay = 3; rd_val = 16'hA5A5;
    push_req(1'b0, 25'h1000010, 16'h0000, 1'b0);
    b0 = busy_cnt;
    issue(2'b01, 25'h1000010, 16'h0000);
    wait_done("rd1", b0);
    check_eq("rd1_busy", 32'(busy_cnt - b0), 32'd6);
    check_eq("rd1_data", 32'(bus.rdData), 32'hA5A5);
    check_eq("rd1_q", 32'(exp_q.size()), 32'd0);

    // Read, ack and data in the same cycle
    rv_delay = 0; rd_val = 16'h5A3C;
    push_req(1'b0, 25'h0ABCDEF, 16'h0000, 1'b0);
    b0 = busy_cnt;
    issue(2'b01, 25'h0ABCDEF, 16'h1234);
    wait_done("rd2", b0);
    check_eq("rd2_busy", 32'(busy_cnt - b0), 32'd3);
    check_eq("rd2_data", 32'(bus.rdData), 32'h5A3C);

    // Clear sweep over 8 words, ack always on the first request cycle
    for (int i = 0; i < 8; i++) push_req(1'b1, 25'(i), 16'h0000, 1'b1);
    b0 = busy_cnt; r0 = req_rise_cnt; d0 = done_rise_cnt;
    issue(2'b00, 25'h1FFFFFF, 16'hFFFF);
    wait_done("clr", b0);
    check_eq("clr_busy", 32'(busy_cnt - b0), 32'd25);
    check_eq("clr_reqs", 32'(req_rise_cnt - r0), 32'd8);
    check_eq("clr_done_rise", 32'(done_rise_cnt - d0), 32'd1);
    check_eq("clr_q", 32'(exp_q.size()), 32'd0);
    check_eq("clr_rd_hold", 32'(bus.rdData), 32'h5A3C);

    // Write that is never acknowledged
    ack_delay = 1000;
    push_req(1'b1, 25'h0000055, 16'h1111, 1'b1);
    b0 = busy_cnt; h0 = req_hi_cnt;
    issue(2'b10, 25'h0000055, 16'h1111);
    wait_done("to", b0);
    check_eq("to_busy", 32'(busy_cnt - b0), 32'd12);
    check_eq("to_req_cycles", 32'(req_hi_cnt - h0), 32'd10);
    check_eq("to_err", 32'(bus.errFlag), 32'd1);
    check_eq("to_memReq", 32'(bus.memReq), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check_eq("to_err_sticky", 32'(bus.errFlag), 32'd1);

    // Ack on the limit cycle: no error, and the next command clears errFlag
    ack_delay = 9;
    push_req(1'b1, 25'h0000056, 16'h2222, 1'b1);
    b0 = busy_cnt; h0 = req_hi_cnt;
    issue(2'b10, 25'h0000056, 16'h2222);
    wait_done("lim", b0);
    check_eq("lim_busy", 32'(busy_cnt - b0), 32'd12);
    check_eq("lim_req_cycles", 32'(req_hi_cnt - h0), 32'd10);
    check_eq("lim_err", 32'(bus.errFlag), 32'd0);
    check_eq("lim_q", 32'(exp_q.size()), 32'd0);

    // ioDone held high for 20 cycles
    ack_delay = 0;
    push_req(1'b1, 25'h0000077, 16'h7777, 1'b1);
    r0 = req_rise_cnt;
    @(posedge clk); #2;
    bus.modeIn = 2'b10; bus.addrIn = 25'h0000077; bus.dataIn = 16'h7777; bus.ioDone = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    bus.ioDone = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("hold_reqs", 32'(req_rise_cnt - r0), 32'd1);
    check_eq("hold_done", 32'(bus.memDone), 32'd1);
    check_eq("hold_q", 32'(exp_q.size()), 32'd0);

    // No-op mode
    b0 = busy_cnt; r0 = req_rise_cnt;
    issue(2'b11, 25'h0000099, 16'h9999);
    repeat (6) @(negedge clk);
    #1;
    check_eq("nop_busy", 32'(busy_cnt - b0), 32'd0);
    check_eq("nop_reqs", 32'(req_rise_cnt - r0), 32'd0);
    check_eq("nop_done", 32'(bus.memDone), 32'd1);

    // Second edge while busy is dropped
    ack_delay = 5;
    push_req(1'b1, 25'h0000123, 16'h3333, 1'b1);
    b0 = busy_cnt; r0 = req_rise_cnt;
    issue(2'b10, 25'h0000123, 16'h3333);
    repeat (2) @(posedge clk);
    #2;
    bus.modeIn = 2'b01; bus.addrIn = 25'h0000456; bus.ioDone = 1'b1;
    @(posedge clk); #2;
    bus.ioDone = 1'b0;
    wait_done("busy", b0);
    check_eq("busy_busy", 32'(busy_cnt - b0), 32'd8);
    repeat (6) @(negedge clk);
    #1;
    check_eq("busy_reqs", 32'(req_rise_cnt - r0), 32'd1);
    check_eq("busy_idle", 32'(bus.memDone), 32'd1);
    check_eq("busy_q", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a clear sweep, at word 3
    ack_delay = 0;
    for (int i = 0; i < 8; i++) push_req(1'b1, 25'(i), 16'h0000, 1'b1);
    issue(2'b00, 25'h0000000, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.memReq === 1'b1 && bus.memAddr === 25'd3) found = 1'b1;
    end
    check_eq("mid_reach_w3", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_memReq", 32'(bus.memReq), 32'd0);
    check_eq("mid_memWe", 32'(bus.memWe), 32'd0);
    check_eq("mid_memAddr", 32'(bus.memAddr), 32'd0);
    check_eq("mid_memWdata", 32'(bus.memWdata), 32'd0);
    check_eq("mid_rdData", 32'(bus.rdData), 32'd0);
    check_eq("mid_errFlag", 32'(bus.errFlag), 32'd0);
    check_eq("mid_memDone", 32'(bus.memDone), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);

    // Fresh clear after reset restarts at address 0
    for (int i = 0; i < 8; i++) push_req(1'b1, 25'(i), 16'h0000, 1'b1);
    b0 = busy_cnt; r0 = req_rise_cnt;
    issue(2'b00, 25'h0000005, 16'h0000);
    wait_done("clr2", b0);
    check_eq("clr2_busy", 32'(busy_cnt - b0), 32'd25);
    check_eq("clr2_reqs", 32'(req_rise_cnt - r0), 32'd8);
    check_eq("clr2_q", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_op_sequencer.md
Name: mem_op_sequencer

Overview:
- Sits between the front-panel I/O controller and the SDRAM controller port.
- On the I/O controller's completion strobe, latches mode/address/data and runs one memory operation:
  - single write;
  - single read;
  - clear sweep, which writes zero over a configurable word range.
- Drives a req/ack memory handshake and returns memDone (ready) plus captured read data.
- Flags an error and recovers if the memory stops responding.

Parameters:
- ADDR_W, 25, memory word-address width
- DATA_W, 16, data width
- CLEAR_WORDS, 1024, number of words zeroed by a clear sweep, starting at address 0
- TIMEOUT_CYCLES, 255, max cycles waiting for memAck or memRvalid before error

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ioDone  in  1  command strobe from I/O controller; level, rising edge = new command
- modeIn  in  2  00 clear, 01 read, 10 write, 11 no-op
- addrIn  in  ADDR_W  target address (read/write)
- dataIn  in  DATA_W  write data
- memReq  out  1  request valid to memory controller
- memWe  out  1  1 = write, 0 = read; valid with memReq
- memAddr  out  ADDR_W  request address; valid with memReq
- memWdata  out  DATA_W  write data; valid with memReq
- memAck  in  1  memory accepted request this cycle
- memRvalid  in  1  read data valid this cycle
- memRdata  in  DATA_W  read data
- memDone  out  1  1 = idle/ready for a command; 0 = busy
- rdData  out  DATA_W  last read result, held until the next read completes
- errFlag  out  1  sticky timeout error, cleared when the next command is accepted

Behaviour:
- Reset values (asynchronous):
  - memReq=0, memWe=0, memAddr=0, memWdata=0
  - rdData=0, errFlag=0, memDone=1
  - state IDLE, timer=0, ioDone edge register=0
- Reset mid-operation: memReq drops immediately, the operation is abandoned, no completion is reported.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_RDATA, CLR_NEXT, DONE.
- IDLE:
  - memDone=1.
  - A rising edge of ioDone (registered previous value, 1-cycle detect) latches modeIn/addrIn/dataIn and clears errFlag.
  - mode 11: nothing latched, no state change, stays IDLE.
  - Otherwise -> ISSUE.
  - ioDone held high does not re-trigger.
- ISSUE (1 cycle) drives the request fields; memReq rises the following cycle.
  - write: memWe=1, memAddr=latched addr, memWdata=latched data.
  - read: memWe=0, memAddr=latched addr.
  - clear: memWe=1, memAddr=sweep counter (starts 0), memWdata=0.
  - memDone=0 from ISSUE through DONE.
- WAIT_ACK:
  - memReq=1; address, data and memWe held stable until the cycle memAck=1.
  - memReq deasserts the cycle after ack.
- On ack:
  - write -> DONE.
  - clear -> CLR_NEXT.
  - read -> WAIT_RDATA; if memRvalid=1 in the same cycle as memAck, capture data and go to DONE directly.
- WAIT_RDATA: on memRvalid, rdData<=memRdata -> DONE.
- CLR_NEXT:
  - If counter == CLEAR_WORDS-1 -> DONE.
  - Else counter+1 -> ISSUE.
  - The counter never wraps.
  - Each word takes ISSUE + ≥1 ack cycle + CLR_NEXT.
- Timeout:
  - Timer resets on entering WAIT_ACK or WAIT_RDATA and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES without the awaited event: errFlag=1, memReq=0 -> DONE.
  - A clear sweep aborts at the failing address.
  - If the awaited event arrives on the same cycle as the limit, the event wins and there is no error.
- DONE (1 cycle) -> IDLE; memDone returns to 1 on entry to IDLE.
- Minimum latency, ioDone edge to memDone=1:
  - write with ack on first request cycle: 5 cycles.
  - read: 5 + data wait.
- ioDone edges while busy are ignored, not queued.
- memAck or memRvalid while not awaited is ignored.

Decomposition:
- Package mem_ctrl_pkg:
  - mode constants MODE_CLEAR=2'b00, MODE_READ=2'b01, MODE_WRITE=2'b10, MODE_NOP=2'b11
  - state enum typedef
  - default ADDR_W/DATA_W
- One sub-module, mem_timeout_timer: clear, enable and expire-at-limit counter parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write: modeIn=10, addrIn=25'h0001234, dataIn=16'hBEEF, ioDone rise; memAck on the 2nd request cycle -> exactly one request (memWe=1, memAddr=0x0001234, memWdata=0xBEEF held until ack), memDone low then high, errFlag=0.
- Read: modeIn=01, addrIn=25'h1000010; memAck, then memRvalid 3 cycles later with 16'hA5A5 -> rdData=0xA5A5, memDone=1. Repeat with memAck+memRvalid in the same cycle -> DONE without WAIT_RDATA.
- Clear, CLEAR_WORDS=8, memAck always 1 -> 8 write requests at addresses 0..7, all memWdata=0, one memDone rise at the end, no address 8.
- Timeout, TIMEOUT_CYCLES=10, memAck never asserted on a write -> memReq drops after 10 wait cycles, errFlag=1, memDone=1. Next valid command clears errFlag.
- Edge/no-op: ioDone held high 20 cycles -> exactly one operation. mode 11 edge -> no memReq, memDone stays 1. Second ioDone edge while busy -> ignored.
- Reset mid-clear at word 3 -> memReq=0 immediately and all outputs at reset values. A new clear after reset starts again at address 0.
